// File: rtl/race_start_ctrl_if.sv
// Signal bundle between the race start controller and its neighbours:
// frame/button inputs in, scroll position and status lamps out.
interface race_start_ctrl_if;
  logic        vsync_in;
  logic        start_btn;
  logic        gas_btn;
  logic [31:0] position;
  logic [7:0]  speed;
  logic [2:0]  lights;
  logic        go;
  logic        false_start;
  logic        finished;
  logic [15:0] race_frames;

  modport master (
    output vsync_in, start_btn, gas_btn,
    input  position, speed, lights, go, false_start, finished, race_frames
  );

  modport slave (
    input  vsync_in, start_btn, gas_btn,
    output position, speed, lights, go, false_start, finished, race_frames
  );
endinterface

// File: rtl/race_start_ctrl.sv
// Race start sequencer: three-light countdown, false-start detection and
// per-frame integration of speed into the scroll position.
//
// state   | meaning
// S_IDLE  | waiting for a start button edge, all outputs cleared
// S_COUNT | countdown lamps running, gas on a tick is a false start
// S_RACE  | speed ramps with gas, position integrates once per frame
// S_FINISH| finish line reached, outputs frozen until start edge
// S_FAULT | false start, outputs frozen until start edge
module race_start_ctrl #(
  parameter int unsigned FRAMES_PER_LIGHT = 60,
  parameter int unsigned ACCEL_DIV        = 4,
  parameter int unsigned MAX_SPEED        = 15,
  parameter logic [31:0] FINISH_POS       = 32'd5000
) (
  input  logic             clk,
  input  logic             reset,
  race_start_ctrl_if.slave bus
);

  localparam int unsigned FW = (FRAMES_PER_LIGHT > 1) ? $clog2(FRAMES_PER_LIGHT) : 1;
  localparam int unsigned AW = (ACCEL_DIV > 1) ? $clog2(ACCEL_DIV) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_LIGHT - 1);
  localparam logic [AW-1:0] ACCEL_LAST = AW'(ACCEL_DIV - 1);
  localparam logic [7:0]    MAX_SPD    = 8'(MAX_SPEED);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_RACE,
    S_FINISH,
    S_FAULT
  } state_t;

  state_t      state_q, state_d;
  logic        vsync_prev_q, start_prev_q;
  logic        armed_q;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [AW-1:0] accel_cnt_q, accel_cnt_d;
  logic [31:0] position_q, position_d;
  logic [7:0]  speed_q, speed_d;
  logic [2:0]  lights_q, lights_d;
  logic [15:0] race_frames_q, race_frames_d;

  logic        tick, start_edge;
  logic [31:0] pos_sum;

  // The prev registers clear to 0 on reset, so a line held high through reset
  // would look like an edge; armed_q masks edges for the first cycle after it.
  assign tick       = armed_q & bus.vsync_in  & ~vsync_prev_q;
  assign start_edge = armed_q & bus.start_btn & ~start_prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      vsync_prev_q  <= 1'b0;
      start_prev_q  <= 1'b0;
      armed_q       <= 1'b0;
      frame_cnt_q   <= '0;
      accel_cnt_q   <= '0;
      position_q    <= '0;
      speed_q       <= '0;
      lights_q      <= '0;
      race_frames_q <= '0;
    end else begin
      state_q       <= state_d;
      vsync_prev_q  <= bus.vsync_in;
      start_prev_q  <= bus.start_btn;
      armed_q       <= 1'b1;
      frame_cnt_q   <= frame_cnt_d;
      accel_cnt_q   <= accel_cnt_d;
      position_q    <= position_d;
      speed_q       <= speed_d;
      lights_q      <= lights_d;
      race_frames_q <= race_frames_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    accel_cnt_d   = accel_cnt_q;
    position_d    = position_q;
    speed_d       = speed_q;
    lights_d      = lights_q;
    race_frames_d = race_frames_q;
    pos_sum       = position_q + {24'd0, speed_q};

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d     = S_COUNT;
          lights_d    = 3'b001;
          frame_cnt_d = '0;
        end
      end

      S_COUNT: begin
        if (tick) begin
          if (bus.gas_btn) begin
            state_d = S_FAULT;
          end else if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d = '0;
            case (lights_q)
              3'b001:  lights_d = 3'b011;
              3'b011:  lights_d = 3'b111;
              default: begin
                lights_d    = 3'b000;
                accel_cnt_d = '0;
                state_d     = S_RACE;
              end
            endcase
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end

      S_RACE: begin
        if (tick) begin
          if (race_frames_q != 16'hFFFF) race_frames_d = race_frames_q + 16'd1;

          if (accel_cnt_q == ACCEL_LAST) begin
            accel_cnt_d = '0;
            if (bus.gas_btn) speed_d = (speed_q < MAX_SPD) ? speed_q + 8'd1 : MAX_SPD;
            else             speed_d = (speed_q != 8'd0)   ? speed_q - 8'd1 : 8'd0;
          end else begin
            accel_cnt_d = accel_cnt_q + 1'b1;
          end

          if (pos_sum >= FINISH_POS) begin
            position_d = FINISH_POS;
            state_d    = S_FINISH;
          end else begin
            position_d = pos_sum;
          end
        end
      end

      S_FINISH, S_FAULT: begin
        if (start_edge) begin
          state_d       = S_IDLE;
          frame_cnt_d   = '0;
          accel_cnt_d   = '0;
          position_d    = '0;
          speed_d       = '0;
          lights_d      = '0;
          race_frames_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.position    = position_q;
  assign bus.speed       = speed_q;
  assign bus.lights      = lights_q;
  assign bus.race_frames = race_frames_q;
  assign bus.go          = (state_q == S_RACE);
  assign bus.false_start = (state_q == S_FAULT);
  assign bus.finished    = (state_q == S_FINISH);

endmodule
